ram_line_responder: RTL

RAM_LINE_RESPONDER -- requirements
Module: ram_line_responder

---
 rtl/ram_line_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/ram_line_responder.sv
// Line-granular RAM model that answers cache line reads/writes after a fixed latency.
// One request is in flight at a time; the captured request drives the operation.
module ram_line_responder #(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable_cache_to_ram,
   input  logic         write_cache_to_ram,
   input  logic [31:0]  address_cache_to_ram,
   input  logic [255:0] data_cache_to_ram_i,
   output logic         response_ram_to_cache,
   output logic [255:0] data_ram_to_cache_o,
   output logic [1:0]   state_dbg
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  cap_write;
   logic [DEPTH_LOG2-1:0] cap_idx;
   logic [255:0]          cap_data;
   logic                  capture;
   logic                  commit;
   logic [255:0]          mem [DEPTH];

   // Byte-offset bits and everything above the index are dropped, so addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{address_cache_to_ram[31:DEPTH_LOG2+5], address_cache_to_ram[4:0]};

   assign state_dbg = state;

   always_comb begin
      state_nxt             = state;
      cnt_nxt               = cnt;
      capture               = 1'b0;
      commit                = 1'b0;
      response_ram_to_cache = 1'b0;
      case (state)
         IDLE: begin
            if (enable_cache_to_ram) begin
               capture   = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               commit    = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            response_ram_to_cache = 1'b1;
            state_nxt             = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_write <= 1'b0;
         cap_idx   <= '0;
         cap_data  <= '0;
      end else if (capture) begin
         cap_write <= write_cache_to_ram;
         cap_idx   <= address_cache_to_ram[DEPTH_LOG2+4:5];
         cap_data  <= data_cache_to_ram_i;
      end
   end

   // The read port only moves on read completion, so writes never disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_ram_to_cache_o <= '0;
      end else if (commit && !cap_write) begin
         data_ram_to_cache_o <= mem[cap_idx];
      end
   end

   // Storage is deliberately not reset; reset during BUSY leaves commit low.
   always_ff @(posedge clk) begin
      if (commit && cap_write) begin
         mem[cap_idx] <= cap_data;
      end
   end

endmodule
